tff_bank_sequencer: RTL

TFF_BANK_SEQUENCER -- requirements
Module: tff_bank_sequencer

---
 rtl/tff_bank_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/tff_bank_sequencer.sv
// Sequencer that steers an external T flip-flop bank to a target value, either by
// counting up/down one step per cycle or by a single-cycle direct load.
module tff_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   steps
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic             r_down;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH:0]   r_steps;

  logic [WIDTH-1:0] w_upT;
  logic [WIDTH-1:0] w_downT;
  logic [WIDTH-1:0] w_diff;
  logic             w_atTarget;
  logic             w_stepsMax;

  assign w_diff     = q ^ r_target;
  assign w_atTarget = (q == r_target);
  assign w_stepsMax = &r_steps;

  // Ripple toggle chains: a bit toggles once every lower bit is at its carry/borrow value.
  always_comb begin
    w_upT      = '0;
    w_downT    = '0;
    w_upT[0]   = 1'b1;
    w_downT[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_upT[i]   = w_upT[i-1] & q[i-1];
      w_downT[i] = w_downT[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    t = '0;
    case (r_state)
      S_LOAD: if (!abort) t = w_diff;
      S_RUN:  if (!abort && !w_atTarget) t = r_down ? w_downT : w_upT;
      default: t = '0;
    endcase
  end

  // Abort wins over reaching the target; steps is left untouched on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_down   <= 1'b0;
      r_target <= '0;
      r_steps  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_down   <= mode[0];
            r_target <= target;
            r_steps  <= '0;
            r_state  <= mode[1] ? S_LOAD : S_RUN;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_steps <= {{WIDTH{1'b0}}, |w_diff};
            r_state <= S_DONE;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_atTarget) begin
            r_state <= S_DONE;
          end else if (!w_stepsMax) begin
            r_steps <= r_steps + {{WIDTH{1'b0}}, 1'b1};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign steps = r_steps;

endmodule
